// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port integer register file for the core pipeline.
//
// Two write ports (port 1 wins on an address collision), NUM_RD combinational
// read ports with write-to-read forwarding, optional hardwired-zero register,
// a clear sequencer that zeroes the array after reset or on request, and a
// per-register pending scoreboard for decode-side hazard detection.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   we0/waddr0/wdata0        write port 0
//   we1/waddr1/wdata1        write port 1 (priority over port 0)
//   re, raddr                per-port read enable, packed read addresses
//   rdata, rpend             packed read data, per-port pending flag
//   sb_set, sb_addr          mark a register pending (new producer issued)
//   clr_req                  request a full array clear
//   ready                    array valid; reads and writes honoured
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweeping: write 0 to mem[cnt] each cycle, ready = 0
// ST_IDLE  | array valid, ready = 1, normal read/write/scoreboard operation
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     clr_req,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic wr0_ok, wr1_ok, sb_ok, clr_go;

  assign ready  = (state_q == ST_IDLE);
  assign clr_go = ready && clr_req;

  // Honoured writes / scoreboard sets: only when ready, never to r0 if hardwired.
  assign wr0_ok = ready && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok = ready && we1 && !((ZERO_REG != 0) && (waddr1 == '0));
  assign sb_ok  = ready && sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // clr_req is only looked at here, so a request during a sweep
        // never restarts it.
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Order matters: port 1 clears after port 0, and a same-cycle sb_set is
  // applied last so the newly issued producer keeps the bit set.  A clear
  // request wipes everything.
  always_comb begin
    pend_d = pend_q;
    if (wr0_ok) pend_d[waddr0] = 1'b0;
    if (wr1_ok) pend_d[waddr1] = 1'b0;
    if (sb_ok)  pend_d[sb_addr] = 1'b1;
    if (clr_go) pend_d = '0;
  end

  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[cnt_q[ADDR_W-1:0]] = '0;
    end else begin
      if (wr0_ok) mem_d[waddr0] = wdata0;
      if (wr1_ok) mem_d[waddr1] = wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // The array itself has no reset; the sweep zeroes it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_zero;
    logic              wr_hit;
    logic [DATA_W-1:0] rd;

    assign ra      = raddr[g*ADDR_W +: ADDR_W];
    assign ra_zero = (ZERO_REG != 0) && (ra == '0);
    assign wr_hit  = (wr0_ok && (waddr0 == ra)) || (wr1_ok && (waddr1 == ra));

    always_comb begin
      rd = '0;
      if (!ready || !re[g] || ra_zero) rd = '0;
      else if (we1 && (waddr1 == ra))  rd = wdata1;
      else if (we0 && (waddr0 == ra))  rd = wdata0;
      else                             rd = mem_q[ra];
    end

    assign rdata[g*DATA_W +: DATA_W] = rd;
    assign rpend[g] = re[g] && ready && pend_q[ra] && !wr_hit && !ra_zero;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised next-generation integer register file for the core pipeline.
- Features: configurable data width, depth and read-port count; two write ports with fixed priority; write-to-read forwarding; hardwired-zero register option; built-in clear sequencer that zeroes the array after reset or on request; per-register pending scoreboard for hazard detection.
- Sits between decode (reads, scoreboard set) and writeback (writes).

Parameters:
DATA_W  32  register width in bits
ADDR_W  5  address width; DEPTH = 2**ADDR_W registers
NUM_RD  2  number of read ports (1..4)
ZERO_REG  1  1: register 0 reads as zero, ignores writes and is never pending

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
we0  input  1  write port 0 enable
waddr0  input  ADDR_W  write port 0 address
wdata0  input  DATA_W  write port 0 data
we1  input  1  write port 1 enable (priority over port 0)
waddr1  input  ADDR_W  write port 1 address
wdata1  input  DATA_W  write port 1 data
re  input  NUM_RD  per-port read enable
raddr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rdata  output  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
rpend  output  NUM_RD  per-port "source register pending" flag
sb_set  input  1  mark register sb_addr pending
sb_addr  input  ADDR_W  scoreboard set address
clr_req  input  1  request full array clear
ready  output  1  array valid; writes and reads honoured

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM -> CLEAR; sweep counter = 0; ready = 0; all pending bits = 0.
  - Array is not reset directly; it is zeroed by the sweep.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle write 0 to regs[cnt], then cnt++.
  - When cnt == DEPTH-1 is written, go to IDLE; ready = 1 from the next cycle.
  - Result: ready rises exactly DEPTH rising edges after rst deasserts.
  - IDLE with clr_req = 1 at an edge: -> CLEAR, cnt = 0, ready = 0 next cycle, all pending bits cleared.
  - clr_req while in CLEAR: ignored; the sweep is not restarted.
  - rst asserted mid-sweep: immediate return to CLEAR with cnt = 0.
- Writes (registered, only when ready = 1):
  - we0/we1 write on the rising edge.
  - If ZERO_REG = 1, writes to address 0 are dropped.
  - we0 and we1 to the same address in the same cycle: wdata1 is stored.
  - Writes while ready = 0 are dropped.
- Reads (combinational, zero latency). Per port i, in priority order:
  1. ready = 0 or re[i] = 0 -> 0.
  2. ZERO_REG = 1 and raddr_i = 0 -> 0.
  3. we1 and waddr1 = raddr_i -> wdata1 (forward).
  4. we0 and waddr0 = raddr_i -> wdata0 (forward).
  5. Otherwise regs[raddr_i].
- Scoreboard: one pending bit per register.
  - sb_set sets pend[sb_addr] at the edge; ignored while ready = 0 and for address 0 when ZERO_REG = 1.
  - An honoured write by either port clears pend[waddr].
  - sb_set and a write to the same address in the same cycle: the bit ends set (the new producer wins).
- rpend[i] = re[i] & ready & pend[raddr_i] & ~(same-cycle honoured write to raddr_i); 0 for address 0 when ZERO_REG = 1.
- Output reset values: rdata = 0, rpend = 0, ready = 0.
- Width rules:
  - Sweep counter is ADDR_W+1 bits wide, so it holds DEPTH without overflow.
  - Address compares are full ADDR_W bits.
  - No arithmetic on data.

Test Plan:
- Reset release, defaults (DEPTH=32) -> ready low for 32 edges, high from edge 32. Reads of regs 0..31 then all return 0x0000_0000.
- Write 0xDEAD_BEEF to r5 via we0; same cycle read raddr port0 = 5 -> rdata0 = 0xDEAD_BEEF (forwarded); next cycle also 0xDEAD_BEEF from array.
- we0 r7 = 0x1111_1111 and we1 r7 = 0x2222_2222 together -> same-cycle read 0x2222_2222; array holds 0x2222_2222 afterwards.
- Write r0 = 0xFFFF_FFFF with ZERO_REG=1 -> r0 reads 0; sb_set r0 -> rpend stays 0.
- sb_set r9, then read r9 -> rpend = 1; writeback we1 r9 in a later cycle -> rpend = 0 in that cycle and after. sb_set and write to r9 in the same cycle -> pend stays 1.
- clr_req in IDLE with r3 = 0x1234_5678 -> ready low for 32 cycles, writes dropped during the sweep, r3 reads 0 after ready returns. rst pulsed low mid-sweep -> sweep restarts, full 32 cycles counted from rst release.
